// File: rtl/md_ctrl_pkg.sv
// Shared encodings and default latencies for the EX-stage multiply/divide unit.
package md_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MULT = 2'b01,
    ST_DIV  = 2'b10
  } md_state_t;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/md_ctrl_if.sv
// Bundle between the EX stage / conflict manager and the multiply/divide controller.
interface md_ctrl_if;

  logic        Start;
  logic [1:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        WriteHI;
  logic        WriteLO;
  logic [31:0] WData;
  logic        MD_Use_D;
  logic        Busy;
  logic        Stall_MD;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output Start, MDOp, A, B, WriteHI, WriteLO, WData, MD_Use_D,
    input  Busy, Stall_MD, Done, HI, LO
  );

  modport slave (
    input  Start, MDOp, A, B, WriteHI, WriteLO, WData, MD_Use_D,
    output Busy, Stall_MD, Done, HI, LO
  );

endinterface

// File: rtl/md_calc.sv
// Combinational 64-bit mult/div result, {HI, LO}, including the MIPS corner cases.
module md_calc
  import md_ctrl_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quot_u;
  logic        [31:0] rem_u;
  logic               div_zero;
  logic               div_ovf;

  assign prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u   = {32'b0, a} * {32'b0, b};
  assign quot_s   = $signed(a) / $signed(b);
  assign rem_s    = $signed(a) % $signed(b);
  assign quot_u   = a / b;
  assign rem_u    = a % b;
  assign div_zero = (b == 32'b0);
  // Only signed division can overflow: most-negative / -1.
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  always_comb begin
    result = 64'b0;
    case (md_op_t'(op))
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV: begin
        if (div_zero)     result = {a, 32'hFFFF_FFFF};
        else if (div_ovf) result = {32'b0, 32'h8000_0000};
        else              result = {rem_s, quot_s};
      end
      MD_DIVU: begin
        if (div_zero) result = {a, 32'hFFFF_FFFF};
        else          result = {rem_u, quot_u};
      end
      default: result = 64'b0;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide controller: fixed-latency sequencing, HI/LO ownership, D-stage stall request.
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input logic     Clk,
  input logic     Reset,
  md_ctrl_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  md_state_t        state;
  logic [CNT_W-1:0] counter;
  logic [63:0]      pending;
  logic [63:0]      calc_result;
  logic [31:0]      hi;
  logic [31:0]      lo;
  logic             busy;
  logic             done;

  md_calc u_calc (
    .op     (bus.MDOp),
    .a      (bus.A),
    .b      (bus.B),
    .result (calc_result)
  );

  // Result is captured at Start so the forwarded operands may change while busy.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= ST_IDLE;
      counter <= '0;
      pending <= 64'b0;
      hi      <= 32'b0;
      lo      <= 32'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.Start) begin
            pending <= calc_result;
            busy    <= 1'b1;
            if (bus.MDOp[1]) begin
              state   <= ST_DIV;
              counter <= CNT_W'(DIV_CYCLES - 1);
            end else begin
              state   <= ST_MULT;
              counter <= CNT_W'(MULT_CYCLES - 1);
            end
          end else begin
            if (bus.WriteHI) hi <= bus.WData;
            if (bus.WriteLO) lo <= bus.WData;
          end
        end
        ST_MULT, ST_DIV: begin
          if (counter == '0) begin
            {hi, lo} <= pending;
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            counter <= counter - CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy     = busy;
  assign bus.Done     = done;
  assign bus.HI       = hi;
  assign bus.LO       = lo;
  // The Start cycle itself must stall a following md-class instruction in D.
  assign bus.Stall_MD = bus.MD_Use_D & (bus.Start | busy);

endmodule

// File: tb/tb_md_ctrl.sv
// Randomized scoreboard bench for md_ctrl against an arithmetic reference model.
module tb_md_ctrl;
  import md_ctrl_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  logic        Clk   = 1'b0;
  logic        Reset = 1'b1;
  int          checks = 0;
  int          errors = 0;
  int          illegal_seen = 0;
  int          busy_run = 0;
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] model_hi = 32'b0;
  logic [31:0] model_lo = 32'b0;

  md_ctrl_if bus ();

  md_ctrl #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: 64-bit arithmetic on extended operands, so overflow needs no special case.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'b00: return sa * sb;
      2'b01: return ua * ub;
      default: begin
        if (b == 32'b0) return {a, 32'hFFFF_FFFF};
        if (op == 2'b10) begin
          q = sa / sb;
          r = sa - q * sb;
          return {r[31:0], q[31:0]};
        end
        uq = ua / ub;
        ur = ua - uq * ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  // Monitor: every Done pulse pops one expected commit.
  always @(negedge Clk) begin
    if (!Reset) begin
      busy_run = 0;
    end else begin
      if (bus.Busy) busy_run++;
      if (bus.Done) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got Done=1 required Done=0 (nothing pending) at %0t", $time);
        end else begin
          mon_e = sb_q.pop_front();
          check_output("commit_hi", bus.HI, mon_e.hi);
          check_output("commit_lo", bus.LO, mon_e.lo);
          check_output("busy_len", 32'(busy_run), 32'(mon_e.lat));
        end
        busy_run = 0;
      end
    end
  end

  always @(posedge Clk) begin
    if (Reset && bus.Busy && (bus.Start || bus.WriteHI || bus.WriteLO)) begin
      illegal_seen++;
      $display("[TB] assertion: md-class request while Busy at %0t", $time);
    end
  end

  task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic use_d, input logic with_write, input logic inject_illegal);
    exp_t        e;
    logic [63:0] r;
    logic [31:0] prev_hi, prev_lo;
    prev_hi = model_hi;
    prev_lo = model_lo;
    r     = ref_result(op, a, b);
    e.hi  = r[63:32];
    e.lo  = r[31:0];
    e.lat = op[1] ? DIV_N : MULT_N;
    @(negedge Clk);
    bus.Start    = 1'b1;
    bus.MDOp     = op;
    bus.A        = a;
    bus.B        = b;
    bus.MD_Use_D = use_d;
    bus.WriteHI  = with_write;
    bus.WriteLO  = with_write;
    bus.WData    = $urandom;
    sb_q.push_back(e);
    model_hi = e.hi;
    model_lo = e.lo;
    #1 check_output("stall_start", 32'(bus.Stall_MD), 32'(use_d));
    for (int i = 0; i < e.lat; i++) begin
      @(negedge Clk);
      bus.Start   = 1'b0;
      bus.WriteHI = 1'b0;
      bus.WriteLO = 1'b0;
      bus.A       = $urandom;
      bus.B       = $urandom;
      if (inject_illegal && i == 1) begin
        bus.WriteLO = 1'b1;
        bus.WData   = $urandom;
      end
      #1;
      check_output("busy_high", 32'(bus.Busy), 32'd1);
      check_output("stall_busy", 32'(bus.Stall_MD), 32'(use_d));
      check_output("hold_hi", bus.HI, prev_hi);
      check_output("hold_lo", bus.LO, prev_lo);
    end
    @(negedge Clk);
    bus.WriteLO = 1'b0;
    #1;
    check_output("busy_low", 32'(bus.Busy), 32'd0);
    check_output("stall_after", 32'(bus.Stall_MD), 32'd0);
    bus.MD_Use_D = 1'b0;
  endtask

  task automatic write_hilo(input logic whi, input logic wlo, input logic [31:0] data);
    @(negedge Clk);
    bus.WriteHI  = whi;
    bus.WriteLO  = wlo;
    bus.WData    = data;
    bus.MD_Use_D = 1'($urandom_range(0, 1));
    if (whi) model_hi = data;
    if (wlo) model_lo = data;
    #1 check_output("stall_idle", 32'(bus.Stall_MD), 32'd0);
    @(negedge Clk);
    bus.WriteHI  = 1'b0;
    bus.WriteLO  = 1'b0;
    bus.MD_Use_D = 1'b0;
    #1;
    check_output("mt_hi", bus.HI, model_hi);
    check_output("mt_lo", bus.LO, model_lo);
    check_output("mt_busy", 32'(bus.Busy), 32'd0);
    check_output("mt_done", 32'(bus.Done), 32'd0);
  endtask

  task automatic reset_abort();
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.MDOp  = MD_DIV;
    bus.A     = 32'h7654_3210;
    bus.B     = 32'h0000_0013;
    @(negedge Clk);
    bus.Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    #2 Reset = 1'b0;
    model_hi = 32'b0;
    model_lo = 32'b0;
    #1;
    check_output("rst_hi", bus.HI, 32'b0);
    check_output("rst_lo", bus.LO, 32'b0);
    check_output("rst_busy", 32'(bus.Busy), 32'd0);
    check_output("rst_done", 32'(bus.Done), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (15) @(negedge Clk);
    #1;
    check_output("post_rst_hi", bus.HI, 32'b0);
    check_output("post_rst_lo", bus.LO, 32'b0);
    check_output("post_rst_busy", 32'(bus.Busy), 32'd0);
  endtask

  initial begin
    #1000000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int          sel;
    bus.Start    = 1'b0;
    bus.MDOp     = 2'b00;
    bus.A        = 32'b0;
    bus.B        = 32'b0;
    bus.WriteHI  = 1'b0;
    bus.WriteLO  = 1'b0;
    bus.WData    = 32'b0;
    bus.MD_Use_D = 1'b0;
    #1 Reset = 1'b0;
    repeat (2) @(negedge Clk);
    #1;
    check_output("reset_hi", bus.HI, 32'b0);
    check_output("reset_lo", bus.LO, 32'b0);
    check_output("reset_busy", 32'(bus.Busy), 32'd0);
    check_output("reset_done", 32'(bus.Done), 32'd0);
    check_output("reset_stall", 32'(bus.Stall_MD), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;

    $display("[TB] directed operations");
    apply_stimulus(MD_MULT,  32'hFFFF_FFFD, 32'd5,        1'b1, 1'b0, 1'b0);
    apply_stimulus(MD_MULTU, 32'hFFFF_FFFF, 32'd2,        1'b0, 1'b0, 1'b0);
    apply_stimulus(MD_MULT,  32'hFFFF_FFFF, 32'd2,        1'b0, 1'b0, 1'b0);
    apply_stimulus(MD_DIV,   32'hFFFF_FFF9, 32'd2,        1'b1, 1'b0, 1'b0);
    apply_stimulus(MD_DIVU,  32'd7,         32'd0,        1'b0, 1'b0, 1'b0);
    apply_stimulus(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    apply_stimulus(MD_DIV,   32'h0000_0011, 32'hFFFF_FFFB, 1'b0, 1'b0, 1'b0);

    $display("[TB] mthi/mtlo");
    write_hilo(1'b1, 1'b0, 32'h1234_5678);
    write_hilo(1'b0, 1'b1, 32'h0BAD_F00D);
    write_hilo(1'b1, 1'b1, 32'hCAFE_0001);

    $display("[TB] start with simultaneous write, and write while busy");
    apply_stimulus(MD_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b1, 1'b0);
    apply_stimulus(MD_MULT,  32'd3,         32'd4,         1'b1, 1'b0, 1'b1);

    $display("[TB] randomized operations");
    for (int n = 0; n < 40; n++) begin
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'b0;
      else if (sel == 1) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end else if (sel == 2) begin
        a = 32'($signed(12'($urandom)));
        b = 32'($signed(6'($urandom)));
      end
      apply_stimulus(op, a, b, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'b0);
      if ($urandom_range(0, 2) == 0)
        write_hilo(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end

    $display("[TB] reset during divide");
    write_hilo(1'b1, 1'b1, 32'hA5A5_5A5A);
    reset_abort();

    check_output("illegal_flagged", 32'(illegal_seen), 32'd1);
    check_output("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
